// File: rtl/evm_stack.sv
// Operand stack commit stage: applies interpreter push/pop results to a DEPTH-entry stack.
// Optional EVM_STACK_HIGH_WATER_EN adds a high_water output tracking peak height.
module evm_stack #(
  parameter int DEPTH  = 1024,
  parameter int WIDTH  = 256,
  parameter int WINDOW = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in [0:WINDOW-1],
  input  logic [4:0]       push_num,
  input  logic [4:0]       pop_num,
  input  logic             exit_in,
  output logic [WIDTH-1:0] stack_data [0:WINDOW-1],
  output logic [10:0]      stack_height,
`ifdef EVM_STACK_HIGH_WATER_EN
  output logic [10:0]      high_water,
`endif
  output logic             halted,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int HW = 11;
  localparam int HX = HW + 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {RUN, HALT} state_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_UNDER = 2'd1,
    ERR_OVER  = 2'd2,
    ERR_COUNT = 2'd3
  } err_code_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   height_q, height_d;
  logic            err_q, err_d;
  err_code_t       code_q, code_d;
  logic            wr_en;
  logic [HX-1:0]   h_ext;
  logic [HX-1:0]   new_h;
  logic [HX-1:0]   rd_idx  [WINDOW];
  logic [AW-1:0]   wr_addr [WINDOW];
  logic [WIDTH-1:0] mem [DEPTH];

`ifdef EVM_STACK_HIGH_WATER_EN
  logic [HW-1:0]   hw_q, hw_d;
`endif

  assign h_ext = HX'(height_q);
  assign new_h = h_ext - HX'(pop_num) + HX'(push_num);

  always_comb begin
    state_d  = state_q;
    height_d = height_q;
    err_d    = err_q;
    code_d   = code_q;
    wr_en    = 1'b0;
`ifdef EVM_STACK_HIGH_WATER_EN
    hw_d     = hw_q;
`endif
    if (clear) begin
      state_d  = RUN;
      height_d = '0;
      err_d    = 1'b0;
      code_d   = ERR_NONE;
`ifdef EVM_STACK_HIGH_WATER_EN
      hw_d     = '0;
`endif
    end else if (in_valid && state_q == RUN) begin
      if (exit_in) begin
        state_d = HALT;
      end else if (push_num > 5'(WINDOW) || pop_num > 5'(WINDOW)) begin
        state_d = HALT;
        err_d   = 1'b1;
        code_d  = ERR_COUNT;
      end else if (HX'(pop_num) > h_ext) begin
        state_d = HALT;
        err_d   = 1'b1;
        code_d  = ERR_UNDER;
      end else if (new_h > HX'(DEPTH)) begin
        state_d = HALT;
        err_d   = 1'b1;
        code_d  = ERR_OVER;
      end else begin
        height_d = new_h[HW-1:0];
        wr_en    = 1'b1;
`ifdef EVM_STACK_HIGH_WATER_EN
        if (new_h[HW-1:0] > hw_q) hw_d = new_h[HW-1:0];
`endif
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < WINDOW; i++) begin
      logic [HX-1:0] wa;
      wa         = new_h - HX'(i) - HX'(1);
      wr_addr[i] = wa[AW-1:0];
      rd_idx[i]  = h_ext - HX'(i) - HX'(1);
      if (HX'(i) < h_ext) stack_data[i] = mem[rd_idx[i][AW-1:0]];
      else                stack_data[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      height_q <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
`ifdef EVM_STACK_HIGH_WATER_EN
      hw_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      height_q <= height_d;
      err_q    <= err_d;
      code_q   <= code_d;
`ifdef EVM_STACK_HIGH_WATER_EN
      hw_q     <= hw_d;
`endif
    end
  end

  // Storage is not reset; entries at or above height are masked on read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < WINDOW; i++) begin
        if (5'(i) < push_num) mem[wr_addr[i]] <= data_in[i];
      end
    end
  end

  assign in_ready     = (state_q == RUN);
  assign halted       = (state_q == HALT);
  assign stack_height = height_q;
  assign err          = err_q;
  assign err_code     = code_q;
`ifdef EVM_STACK_HIGH_WATER_EN
  assign high_water   = hw_q;
`endif

endmodule

// File: tb/tb_evm_stack.sv
// Directed self-checking bench for evm_stack (default parameters).
module tb_evm_stack;

  logic         clk;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] data_in    [0:16];
  logic [4:0]   push_num;
  logic [4:0]   pop_num;
  logic         exit_in;
  logic [255:0] stack_data [0:16];
  logic [10:0]  stack_height;
`ifdef EVM_STACK_HIGH_WATER_EN
  logic [10:0]  high_water;
`endif
  logic         halted;
  logic         err;
  logic [1:0]   err_code;

  int checks;
  int failures;

  evm_stack #(.DEPTH(1024), .WIDTH(256), .WINDOW(17)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .push_num    (push_num),
    .pop_num     (pop_num),
    .exit_in     (exit_in),
    .stack_data  (stack_data),
    .stack_height(stack_height),
`ifdef EVM_STACK_HIGH_WATER_EN
    .high_water  (high_water),
`endif
    .halted      (halted),
    .err         (err),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_data();
    for (int i = 0; i < 17; i++) data_in[i] = '0;
  endtask

  task automatic commit(input int push, input int pop, input logic ex);
    @(negedge clk);
    push_num = 5'(push);
    pop_num  = 5'(pop);
    exit_in  = ex;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exit_in  = 1'b0;
  endtask

  task automatic pulse_clear(input logic with_valid, input int push);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = with_valid;
    push_num = 5'(push);
    pop_num  = '0;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    exit_in  = 1'b0;
    push_num = '0;
    pop_num  = '0;
    clear_data();
    repeat (3) @(posedge clk);
    #1;
    check("rst_height", 256'(stack_height), 256'd0);
    check("rst_ready", 256'(in_ready), 256'd1);
    check("rst_halted", 256'(halted), 256'd0);
    check("rst_err", 256'(err), 256'd0);
    check("rst_code", 256'(err_code), 256'd0);
    check("rst_top", stack_data[0], 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three single pushes
    data_in[0] = 256'hA; commit(1, 0, 1'b0);
    data_in[0] = 256'hB; commit(1, 0, 1'b0);
    data_in[0] = 256'hC; commit(1, 0, 1'b0);
    check("push3_height", 256'(stack_height), 256'd3);
    check("push3_sd0", stack_data[0], 256'hC);
    check("push3_sd1", stack_data[1], 256'hB);
    check("push3_sd2", stack_data[2], 256'hA);
    check("push3_sd3", stack_data[3], 256'd0);

    // SWAP1
    data_in[0] = 256'hB; data_in[1] = 256'hC; commit(2, 2, 1'b0);
    check("swap_height", 256'(stack_height), 256'd3);
    check("swap_sd0", stack_data[0], 256'hB);
    check("swap_sd1", stack_data[1], 256'hC);
    check("swap_sd2", stack_data[2], 256'hA);

    clear_data();
    commit(0, 0, 1'b0);
    check("noop_height", 256'(stack_height), 256'd3);
    check("noop_sd0", stack_data[0], 256'hB);

    commit(0, 3, 1'b0);
    check("popall_height", 256'(stack_height), 256'd0);
    check("popall_sd0", stack_data[0], 256'd0);
    check("popall_err", 256'(err), 256'd0);

    // Underflow from empty
    data_in[0] = 256'h11; commit(1, 1, 1'b0);
    check("under_err", 256'(err), 256'd1);
    check("under_code", 256'(err_code), 256'd1);
    check("under_halted", 256'(halted), 256'd1);
    check("under_ready", 256'(in_ready), 256'd0);
    check("under_height", 256'(stack_height), 256'd0);
    commit(1, 0, 1'b0);
    check("halt_ignore_height", 256'(stack_height), 256'd0);
    check("halt_ignore_halted", 256'(halted), 256'd1);
    pulse_clear(1'b0, 0);
    check("clr_err", 256'(err), 256'd0);
    check("clr_code", 256'(err_code), 256'd0);
    check("clr_halted", 256'(halted), 256'd0);
    check("clr_ready", 256'(in_ready), 256'd1);

    // Bad count
    commit(18, 0, 1'b0);
    check("badcnt_code", 256'(err_code), 256'd3);
    check("badcnt_halted", 256'(halted), 256'd1);
    check("badcnt_height", 256'(stack_height), 256'd0);
    pulse_clear(1'b0, 0);

    // Fill to exactly DEPTH with 64 commits of 16 words
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 16; i++) data_in[i] = 256'(32'h1000 + k * 16 + i);
      commit(16, 0, 1'b0);
    end
    check("full_height", 256'(stack_height), 256'd1024);
    check("full_ready", 256'(in_ready), 256'd1);
    check("full_err", 256'(err), 256'd0);
    check("full_sd0", stack_data[0], 256'h13F0);
    check("full_sd16", stack_data[16], 256'h13E0);
`ifdef EVM_STACK_HIGH_WATER_EN
    check("full_hw", 256'(high_water), 256'd1024);
`endif
    clear_data();
    data_in[0] = 256'hDEAD; commit(1, 0, 1'b0);
    check("over_code", 256'(err_code), 256'd2);
    check("over_err", 256'(err), 256'd1);
    check("over_height", 256'(stack_height), 256'd1024);
    check("over_sd0", stack_data[0], 256'h13F0);
    pulse_clear(1'b0, 0);
    check("clr_full_height", 256'(stack_height), 256'd0);
`ifdef EVM_STACK_HIGH_WATER_EN
    check("clr_full_hw", 256'(high_water), 256'd0);
`endif

    // Exit
    data_in[0] = 256'h55; commit(1, 0, 1'b0);
    data_in[0] = 256'h66; commit(1, 0, 1'b1);
    check("exit_halted", 256'(halted), 256'd1);
    check("exit_err", 256'(err), 256'd0);
    check("exit_code", 256'(err_code), 256'd0);
    check("exit_height", 256'(stack_height), 256'd1);
    check("exit_sd0", stack_data[0], 256'h55);
    data_in[0] = 256'h77; pulse_clear(1'b1, 1);
    check("clrv_halt_height", 256'(stack_height), 256'd0);
    check("clrv_halt_halted", 256'(halted), 256'd0);
    pulse_clear(1'b1, 1);
    check("clrv_run_height", 256'(stack_height), 256'd0);
    check("clrv_run_sd0", stack_data[0], 256'd0);

    // Push 5, pop 3
    for (int i = 0; i < 5; i++) data_in[i] = 256'(8'h20 + i);
    commit(5, 0, 1'b0);
    clear_data();
    commit(0, 3, 1'b0);
    check("hw_height", 256'(stack_height), 256'd2);
    check("hw_sd0", stack_data[0], 256'h23);
    check("hw_sd1", stack_data[1], 256'h24);
    check("hw_sd2", stack_data[2], 256'd0);
`ifdef EVM_STACK_HIGH_WATER_EN
    check("hw_value", 256'(high_water), 256'd5);
    pulse_clear(1'b0, 0);
    check("hw_clr", 256'(high_water), 256'd0);
    for (int i = 0; i < 2; i++) data_in[i] = 256'(8'h23 + i);
    commit(2, 0, 1'b0);
`endif

    // Async reset during a commit discards it
    @(negedge clk);
    data_in[0] = 256'h99;
    push_num = 5'd1;
    pop_num  = 5'd0;
    in_valid = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("rstmid_height", 256'(stack_height), 256'd0);
    check("rstmid_halted", 256'(halted), 256'd0);
    check("rstmid_sd0", stack_data[0], 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid_after_height", 256'(stack_height), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/evm_stack.md
Name: evm_stack

Overview:
- Operand-stack storage stage sitting directly downstream of the instruction interpreter. It consumes the interpreter's per-instruction result (data words, push/pop counts, exit flag) and commits it to a DEPTH-entry stack of WIDTH-bit words.
- It feeds the top WINDOW entries and the current height back to the interpreter for the next instruction.
- It detects underflow, overflow and bad counts, and halts on exit or error until cleared.

Parameters:
- DEPTH, 1024, maximum stack entries.
- WIDTH, 256, bits per stack word.
- WINDOW, 17, number of top entries exposed and max words written per commit.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous: empty stack, drop error, leave HALT.
- in_valid  in  1  interpreter result valid this cycle.
- in_ready  out  1  stage accepts a commit (state RUN).
- data_in  in  WIDTH x WINDOW (unpacked [0:16])  words to push; [0] becomes new top.
- push_num  in  5  words to push, 0..WINDOW.
- pop_num  in  5  words to pop, 0..WINDOW.
- exit_in  in  1  interpreter exit/revert request.
- stack_data  out  WIDTH x WINDOW (unpacked [0:16])  [0]=top; entries at or beyond height read 0.
- stack_height  out  11  current entry count, 0..DEPTH.
- halted  out  1  state HALT.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 underflow, 2 overflow, 3 bad count.

Behaviour:
- Reset (rst_n low, async): height=0, state RUN, halted=0, err=0, err_code=0, in_ready=1. Storage array is not reset; reads above height are masked to 0.
- States:
  - RUN: in_ready=1.
  - HALT: in_ready=0, halted=1.
- Commit occurs when in_valid && in_ready at a rising edge. Checks are evaluated in priority order:
  1. exit_in=1: no stack change; go to HALT; err unchanged.
  2. push_num>WINDOW or pop_num>WINDOW: err=1, code 3; go to HALT; no change.
  3. pop_num>height: err=1, code 1; go to HALT; no change.
  4. height-pop_num+push_num>DEPTH: err=1, code 2; go to HALT; no change.
  5. Otherwise: h'=height-pop_num+push_num. For i<push_num, write entry[h'-1-i]=data_in[i]. Height becomes h'.
- Arithmetic uses 12-bit intermediates; no wrap.
- Entries below height-pop_num are untouched.
- push_num=pop_num=0 is a legal no-op commit.
- SWAPn convention: pop_num=push_num=n+1 rewrites the top n+1 entries in place.
- Latency: a commit is visible on stack_data/stack_height the cycle after the edge. The window read is combinational from the array and the registered height, so back-to-back commits every cycle are legal.
- in_valid while HALT is ignored; nothing changes.
- clear has priority over a simultaneous commit: height=0, err=0, err_code=0, state RUN. clear while already RUN and empty is a no-op.
- rst_n asserted mid-commit: async reset wins; the commit is discarded.
- err/err_code hold until clear or reset; exit alone never sets err.

Optional Feature:
- EVM_STACK_HIGH_WATER_EN
- Defined: adds output high_water (11 bits), the maximum height reached since reset or clear. It is updated on the same edge as height, reset and cleared to 0.
- Undefined: port and register absent.

Test Plan:
- Three commits, each push_num=1 pop_num=0, data 0xA,0xB,0xC -> height=3; stack_data[0..2]=0xC,0xB,0xA; stack_data[3]=0.
- From that state, commit pop=2 push=2 data_in[0]=0xB, data_in[1]=0xC (SWAP1) -> stack_data[0..1]=0xB,0xC; height=3.
- Empty stack, commit pop_num=1 push_num=1 -> err=1, err_code=1, halted=1, in_ready=0, height=0. Further in_valid is ignored. clear -> err=0, halted=0.
- Fill to height=1024, commit push_num=1 -> err_code=2, height stays 1024, top unchanged.
- Commit with exit_in=1 and push_num=1 -> halted=1, err=0, height unchanged. clear and in_valid together in the same cycle -> height=0, RUN, no push.
- With EVM_STACK_HIGH_WATER_EN defined: push 5, pop 3 -> height=2, high_water=5. clear -> high_water=0.
